// File: rtl/stream_pkg.sv
// Shared constants, lane layout and lock-state encoding for the Aurora stream checker.
package stream_pkg;
  localparam int LANE_WIDTH    = 16;
  localparam int DATA_WIDTH    = 48;
  localparam int SYNC_GOOD_DEF = 4;
  localparam int LOSS_BAD_DEF  = 8;
  localparam int RUN_WIDTH     = 8;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;
endpackage

// File: rtl/stream_frame_checker_if.sv
// Receive-side stream bundle plus checker status; master drives the stream, slave is the checker.
interface stream_frame_checker_if #(
  parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH
);
  logic [0:DATA_WIDTH-1] RX_D;
  logic                  RX_SRC_RDY_N;
  logic                  CHANNEL_UP;
  logic [0:7]            ERR_COUNT;
  logic                  LOCKED;
  logic [31:0]           WORD_COUNT;
  logic                  HB;

  modport master (
    output RX_D, RX_SRC_RDY_N, CHANNEL_UP,
    input  ERR_COUNT, LOCKED, WORD_COUNT, HB
  );

  modport slave (
    input  RX_D, RX_SRC_RDY_N, CHANNEL_UP,
    output ERR_COUNT, LOCKED, WORD_COUNT, HB
  );
endinterface

// File: rtl/stream_word_check.sv
// Combinational word classifier: consistent when A == B and C == ~A, good when also A == expected.
module stream_word_check #(
  parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH
) (
  input  logic [0:DATA_WIDTH-1]             word,
  input  logic [stream_pkg::LANE_WIDTH-1:0] expected,
  output logic                              consistent,
  output logic                              good
);
  import stream_pkg::*;

  logic [LANE_WIDTH-1:0] a, b, c;

  // Bit 0 of the word is the MSB of field A.
  assign a = word[0:LANE_WIDTH-1];
  assign b = word[LANE_WIDTH:2*LANE_WIDTH-1];
  assign c = word[2*LANE_WIDTH:3*LANE_WIDTH-1];

  assign consistent = (a == b) && (c == ~a);
  assign good       = consistent && (a == expected);
endmodule

// File: rtl/stream_frame_checker.sv
// Checks an A=seq, B=seq, C=~seq counting stream: HUNT/SYNC/LOCK tracking, error and word counts,
// heartbeat. All outputs registered, one cycle after the sampled word; idle cycles change nothing.
module stream_frame_checker #(
  parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH,
  parameter int HB_LOG2    = 24,
  parameter int SYNC_GOOD  = stream_pkg::SYNC_GOOD_DEF,
  parameter int LOSS_BAD   = stream_pkg::LOSS_BAD_DEF
) (
  input logic                   USER_CLK,
  input logic                   RESET,
  stream_frame_checker_if.slave bus
);
  import stream_pkg::*;

  state_t                state;
  logic [LANE_WIDTH-1:0] expected;
  logic [RUN_WIDTH-1:0]  good_run;
  logic [RUN_WIDTH-1:0]  bad_run;
  logic [7:0]            err_count;
  logic [31:0]           word_count;
  logic                  locked;
  logic                  hb;
  logic                  consistent;
  logic                  good;
  logic                  valid;

  stream_word_check #(.DATA_WIDTH(DATA_WIDTH)) u_word_check (
    .word       (bus.RX_D),
    .expected   (expected),
    .consistent (consistent),
    .good       (good)
  );

  assign valid = !bus.RX_SRC_RDY_N;

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state      <= HUNT;
      expected   <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      err_count  <= '0;
      word_count <= '0;
      locked     <= 1'b0;
      hb         <= 1'b0;
    end else if (!bus.CHANNEL_UP) begin
      // Channel loss forces a resync; counters keep their history.
      state    <= HUNT;
      locked   <= 1'b0;
      good_run <= '0;
      bad_run  <= '0;
    end else if (valid) begin
      case (state)
        HUNT: begin
          if (consistent) begin
            expected <= bus.RX_D[0:LANE_WIDTH-1] + 1'b1;
            good_run <= RUN_WIDTH'(1);
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (good) begin
            expected <= expected + 1'b1;
            good_run <= good_run + 1'b1;
            if (good_run + 1'b1 == RUN_WIDTH'(SYNC_GOOD)) begin
              state   <= LOCK;
              locked  <= 1'b1;
              bad_run <= '0;
            end
          end else begin
            state    <= HUNT;
            good_run <= '0;
          end
        end
        LOCK: begin
          // Expected advances on bad words too, so one corrupt word costs one error only.
          expected <= expected + 1'b1;
          if (good) begin
            bad_run    <= '0;
            word_count <= word_count + 1'b1;
            if (&word_count[HB_LOG2-1:0]) hb <= ~hb;
          end else begin
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            bad_run <= bad_run + 1'b1;
            if (bad_run + 1'b1 == RUN_WIDTH'(LOSS_BAD)) begin
              state    <= HUNT;
              locked   <= 1'b0;
              bad_run  <= '0;
              good_run <= '0;
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ERR_COUNT  = err_count;
  assign bus.WORD_COUNT = word_count;
  assign bus.LOCKED     = locked;
  assign bus.HB         = hb;
endmodule

// File: tb/tb_stream_frame_checker.sv
// Directed bench for stream_frame_checker: lock/relock, error saturation, channel drop, heartbeat, reset.
module tb_stream_frame_checker;
  logic USER_CLK;
  logic RESET;
  int   n_cmp;
  int   n_err;
  int   exp_err;
  int   exp_wc;
  logic [15:0] s;

  stream_frame_checker_if bus ();

  stream_frame_checker #(.HB_LOG2(2)) dut (
    .USER_CLK (USER_CLK),
    .RESET    (RESET),
    .bus      (bus)
  );

  initial begin
    USER_CLK = 1'b0;
    forever #5 USER_CLK = ~USER_CLK;
  end

  function automatic logic [0:47] mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {a, b, c};
  endfunction

  function automatic logic [0:47] gw(input logic [15:0] q);
    return {q, q, ~q};
  endfunction

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic step(input logic vld, input logic [0:47] d, input logic chup);
    bus.RX_SRC_RDY_N = !vld;
    bus.RX_D         = d;
    bus.CHANNEL_UP   = chup;
    @(negedge USER_CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bad_word();
    step(1'b1, mk(16'h1234, 16'h0000, 16'h0000), 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b1;
    bus.RX_SRC_RDY_N = 1'b1;
    bus.RX_D = '0;
    bus.CHANNEL_UP = 1'b1;
    @(negedge USER_CLK);
    @(negedge USER_CLK);
    check("reset_locked", 32'(bus.LOCKED), 32'd0);
    check("reset_err", 32'(bus.ERR_COUNT), 32'd0);
    check("reset_wc", bus.WORD_COUNT, 32'd0);
    check("reset_hb", 32'(bus.HB), 32'd0);
    RESET = 1'b0;

    step(1'b1, gw(16'h0010), 1'b1);
    step(1'b1, gw(16'h0011), 1'b1);
    step(1'b1, gw(16'h0012), 1'b1);
    check("sync_not_locked_3", 32'(bus.LOCKED), 32'd0);
    step(1'b1, gw(16'h0013), 1'b1);
    check("lock_after_4", 32'(bus.LOCKED), 32'd1);
    check("lock_err0", 32'(bus.ERR_COUNT), 32'd0);
    check("lock_wc0", bus.WORD_COUNT, 32'd0);

    // Single corrupt B lane, then the stream continues from the next sequence number.
    step(1'b1, mk(16'h0014, 16'h0015, ~16'h0014), 1'b1);
    check("corrupt_err1", 32'(bus.ERR_COUNT), 32'd1);
    check("corrupt_locked", 32'(bus.LOCKED), 32'd1);
    step(1'b1, gw(16'h0015), 1'b1);
    check("after_corrupt_wc", bus.WORD_COUNT, 32'd1);
    check("after_corrupt_err", 32'(bus.ERR_COUNT), 32'd1);

    for (int i = 0; i < 7; i++) bad_word();
    check("bad7_still_locked", 32'(bus.LOCKED), 32'd1);
    bad_word();
    check("bad8_unlocked", 32'(bus.LOCKED), 32'd0);
    check("bad8_err", 32'(bus.ERR_COUNT), 32'd9);

    for (int i = 0; i < 4; i++) step(1'b1, gw(16'h0100 + 16'(i)), 1'b1);
    check("relock", 32'(bus.LOCKED), 32'd1);
    check("relock_wc", bus.WORD_COUNT, 32'd1);

    // Heartbeat with HB_LOG2=2 toggles when WORD_COUNT reaches 4 and 8.
    step(1'b1, gw(16'h0104), 1'b1);
    step(1'b1, gw(16'h0105), 1'b1);
    check("hb_wc3", 32'(bus.HB), 32'd0);
    step(1'b1, gw(16'h0106), 1'b1);
    check("hb_wc4", 32'(bus.HB), 32'd1);
    step(1'b1, gw(16'h0107), 1'b1);
    step(1'b1, gw(16'h0108), 1'b1);
    step(1'b1, gw(16'h0109), 1'b1);
    check("hb_wc7", 32'(bus.HB), 32'd1);
    step(1'b1, gw(16'h010A), 1'b1);
    check("hb_wc8", 32'(bus.HB), 32'd0);
    step(1'b1, gw(16'h010B), 1'b1);
    check("hb_wc9", bus.WORD_COUNT, 32'd9);

    step(1'b1, gw(16'h010C), 1'b0);
    check("chdown_locked", 32'(bus.LOCKED), 32'd0);
    check("chdown_wc", bus.WORD_COUNT, 32'd9);
    check("chdown_err", 32'(bus.ERR_COUNT), 32'd9);

    for (int i = 0; i < 4; i++) step(1'b1, gw(16'hFFFA + 16'(i)), 1'b1);
    check("wrap_lock", 32'(bus.LOCKED), 32'd1);
    step(1'b1, gw(16'hFFFE), 1'b1);
    step(1'b1, gw(16'hFFFF), 1'b1);
    step(1'b1, gw(16'h0000), 1'b1);
    step(1'b1, gw(16'h0001), 1'b1);
    check("wrap_err", 32'(bus.ERR_COUNT), 32'd9);
    check("wrap_wc", bus.WORD_COUNT, 32'd13);

    for (int i = 0; i < 3; i++) step(1'b0, mk(16'hDEAD, 16'hBEEF, 16'h0000), 1'b1);
    check("idle_wc", bus.WORD_COUNT, 32'd13);
    check("idle_err", 32'(bus.ERR_COUNT), 32'd9);
    check("idle_locked", 32'(bus.LOCKED), 32'd1);
    step(1'b1, gw(16'h0002), 1'b1);
    check("post_idle_wc", bus.WORD_COUNT, 32'd14);

    // 38 rounds of 8 errors on top of 9 exceed 255 and must saturate.
    exp_err = 9;
    s = 16'h2000;
    for (int r = 0; r < 38; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 4; i++) begin
          step(1'b1, gw(s), 1'b1);
          s = s + 16'd1;
        end
      end else begin
        for (int i = 0; i < 8; i++) step(1'b1, gw(16'h0003 + 16'(i)), 1'b1);
      end
      for (int i = 0; i < 8; i++) bad_word();
      exp_err = (exp_err + 8 > 255) ? 255 : exp_err + 8;
    end
    check("sat_err", 32'(bus.ERR_COUNT), 32'(exp_err));
    check("sat_err_255", 32'(bus.ERR_COUNT), 32'd255);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gw(s), 1'b1);
      s = s + 16'd1;
    end
    check("sat_relock", 32'(bus.LOCKED), 32'd1);
    for (int i = 0; i < 8; i++) bad_word();
    check("sat_hold", 32'(bus.ERR_COUNT), 32'd255);
    check("sat_unlocked", 32'(bus.LOCKED), 32'd0);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, gw(s), 1'b1);
      s = s + 16'd1;
    end
    exp_wc = 14 + 8 + 2;
    check("pre_reset_wc", bus.WORD_COUNT, 32'(exp_wc));
    RESET = 1'b1;
    step(1'b1, gw(s), 1'b1);
    check("midreset_locked", 32'(bus.LOCKED), 32'd0);
    check("midreset_err", 32'(bus.ERR_COUNT), 32'd0);
    check("midreset_wc", bus.WORD_COUNT, 32'd0);
    check("midreset_hb", 32'(bus.HB), 32'd0);
    RESET = 1'b0;
    step(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
